// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - serial binary-to-BCD converter driving a multiplexed seven-segment display
// Optional feature macro: DISPLAY_LEADING_BLANK_EN (blank leading zero digits above digit 0).

module display_scan_ctrl #(
  parameter int DATA_W  = 5,
  parameter int DIGITS  = 2,
  parameter int CLK_DIV = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   value_in,
  input  logic                load,
  output logic                busy,
  output logic                done,
  output logic                ovf,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   digit_en
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  localparam logic [63:0]   OVF_LIMIT  = pow10(DIGITS);
  localparam logic [CW-1:0] CNT_INIT   = CW'(DATA_W);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BW-1:0]     acc_q, acc_adj, acc_d;
  logic [CW-1:0]     cnt_q;
  logic              cand_q, busy_q, done_q, ovf_q;
  logic [BW-1:0]     bcd_q;

  // Double-dabble step: correct nibbles >= 5, then shift one binary bit in.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_d = {acc_adj[BW-2:0], sh_q[DATA_W-1]};
    sh_d  = sh_q << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      cand_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load) begin
            sh_q    <= value_in;
            acc_q   <= '0;
            cnt_q   <= CNT_INIT;
            cand_q  <= (64'(value_in) >= OVF_LIMIT);
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          acc_q <= acc_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= S_COMMIT;
        end
        S_COMMIT: begin
          bcd_q   <= acc_q;
          ovf_q   <= cand_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The scan sees the value being committed on this same edge.
  logic          commit;
  logic [BW-1:0] bcd_d;
  logic          ovf_d;
  assign commit = (state_q == S_COMMIT);
  assign bcd_d  = commit ? acc_q : bcd_q;
  assign ovf_d  = commit ? cand_q : ovf_q;

  logic [PW-1:0]     presc_q;
  logic [IW-1:0]     idx_q, idx_d;
  logic              tick;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] en_q;
  logic [3:0]        nib;

  assign tick  = (presc_q == PRESC_LAST);
  assign idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
  assign nib   = bcd_d[4*idx_d +: 4];

  always_comb begin
    seg_d = seg_decode(nib);
`ifdef DISPLAY_LEADING_BLANK_EN
    if (idx_d != '0 && (bcd_d >> (4*idx_d)) == '0) seg_d = 7'h00;
`endif
    if (ovf_d) seg_d = 7'h40;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= '0;
      en_q    <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        idx_q <= idx_d;
        seg_q <= seg_d;
        en_q  <= DIGITS'(1) << idx_d;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ovf      = ovf_q;
  assign bcd_out  = bcd_q;
  assign seg      = seg_q;
  assign digit_en = en_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - randomized self-checking bench for display_scan_ctrl (2-digit and 1-digit builds)

module tb_display_scan_ctrl;

  localparam int DW = 5;
  localparam int CD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load0 = 1'b0, load1 = 1'b0;
  logic [DW-1:0] val0 = '0, val1 = '0;
  logic          busy0, done0, ovf0, busy1, done1, ovf1;
  logic [7:0]    bcd0;
  logic [3:0]    bcd1;
  logic [6:0]    seg0, seg1;
  logic [1:0]    en0;
  logic [0:0]    en1;

  int n_checks = 0;
  int n_fail = 0;
  int edge_cnt;
  int exp_v0 = 0;
  int exp_v1 = 0;
  int sel = 0;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  display_scan_ctrl #(.DATA_W(DW), .DIGITS(2), .CLK_DIV(CD)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .value_in(val0), .load(load0), .busy(busy0), .done(done0),
    .ovf(ovf0), .bcd_out(bcd0), .seg(seg0), .digit_en(en0)
  );

  display_scan_ctrl #(.DATA_W(DW), .DIGITS(1), .CLK_DIV(CD)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .value_in(val1), .load(load1), .busy(busy1), .done(done1),
    .ovf(ovf1), .bcd_out(bcd1), .seg(seg1), .digit_en(en1)
  );

  logic       s_busy, s_done, s_ovf;
  logic [7:0] s_bcd;
  logic [6:0] s_seg;
  logic [1:0] s_en;
  assign s_busy = (sel == 1) ? busy1 : busy0;
  assign s_done = (sel == 1) ? done1 : done0;
  assign s_ovf  = (sel == 1) ? ovf1 : ovf0;
  assign s_bcd  = (sel == 1) ? {4'h0, bcd1} : bcd0;
  assign s_seg  = (sel == 1) ? seg1 : seg0;
  assign s_en   = (sel == 1) ? {1'b0, en1} : en0;

  function automatic int p10(input int n);
    int p = 1;
    repeat (n) p = p * 10;
    return p;
  endfunction

  function automatic logic [7:0] m_bcd(input int v, input int digits);
    logic [7:0] r = '0;
    for (int i = 0; i < digits; i++) r = r | (8'((v / p10(i)) % 10) << (4 * i));
    return r;
  endfunction

  function automatic logic [6:0] m_glyph(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] m_seg(input int e, input int v, input int digits);
    int idx;
    if (e < CD) return 7'h00;
    idx = (e / CD) % digits;
    if (v >= p10(digits)) return 7'h40;
`ifdef DISPLAY_LEADING_BLANK_EN
    if (idx > 0 && v < p10(idx)) return 7'h00;
`endif
    return m_glyph((v / p10(idx)) % 10);
  endfunction

  function automatic logic [1:0] m_en(input int e, input int digits);
    if (e < CD) return 2'b00;
    return 2'(1 << ((e / CD) % digits));
  endfunction

  task automatic drive(input logic l, input logic [DW-1:0] v);
    if (sel == 1) begin load1 = l; val1 = v; end
    else          begin load0 = l; val0 = v; end
  endtask

  task automatic check_scan(input int ncyc);
    int digits, v;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      digits = (sel == 1) ? 1 : 2;
      v = (sel == 1) ? exp_v1 : exp_v0;
      n_checks += 2;
      if (s_en !== m_en(edge_cnt, digits)) begin
        n_fail++;
        $display("FAIL digit_en dut%0d edge=%0d got=%b exp=%b", sel, edge_cnt, s_en, m_en(edge_cnt, digits));
      end
      if (s_seg !== m_seg(edge_cnt, v, digits)) begin
        n_fail++;
        $display("FAIL seg dut%0d edge=%0d val=%0d got=%h exp=%h", sel, edge_cnt, v, s_seg, m_seg(edge_cnt, v, digits));
      end
    end
  endtask

  task automatic convert(input int which, input int v, input bit inject, input int v2);
    int digits, prev;
    logic exp_b;
    sel = which;
    digits = (sel == 1) ? 1 : 2;
    prev = (sel == 1) ? exp_v1 : exp_v0;
    drive(1'b1, DW'(v));
    for (int j = 1; j <= DW + 3; j++) begin
      @(negedge clk);
      if (j == 1) drive(1'b0, ~DW'(v));
      if (inject && j == 2) drive(1'b1, DW'(v2));
      if (inject && j == 3) drive(1'b0, DW'(v2));
      exp_b = (j <= DW + 1);
      n_checks += 2;
      if (s_busy !== exp_b) begin
        n_fail++;
        $display("FAIL busy dut%0d v=%0d cyc=%0d got=%b exp=%b", sel, v, j, s_busy, exp_b);
      end
      exp_b = (j == DW + 2);
      if (s_done !== exp_b) begin
        n_fail++;
        $display("FAIL done dut%0d v=%0d cyc=%0d got=%b exp=%b", sel, v, j, s_done, exp_b);
      end
      if (j <= DW + 1 && prev < p10(digits)) begin
        n_checks++;
        if (s_bcd !== m_bcd(prev, digits)) begin
          n_fail++;
          $display("FAIL bcd_hold dut%0d cyc=%0d got=%h exp=%h", sel, j, s_bcd, m_bcd(prev, digits));
        end
      end
    end
    if (sel == 1) exp_v1 = v;
    else          exp_v0 = v;
    n_checks++;
    if (s_ovf !== (v >= p10(digits))) begin
      n_fail++;
      $display("FAIL ovf dut%0d v=%0d got=%b exp=%b", sel, v, s_ovf, (v >= p10(digits)));
    end
    if (v < p10(digits)) begin
      n_checks++;
      if (s_bcd !== m_bcd(v, digits)) begin
        n_fail++;
        $display("FAIL bcd dut%0d v=%0d got=%h exp=%h", sel, v, s_bcd, m_bcd(v, digits));
      end
    end
    repeat (CD) @(negedge clk);
    check_scan(2 * digits * CD + 1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks += 6;
    if ({busy0, done0, ovf0, busy1, done1, ovf1} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b exp=000000", {busy0, done0, ovf0, busy1, done1, ovf1});
    end
    if (bcd0 !== 8'h00) begin n_fail++; $display("FAIL reset_bcd0 got=%h exp=00", bcd0); end
    if (bcd1 !== 4'h0)  begin n_fail++; $display("FAIL reset_bcd1 got=%h exp=0", bcd1); end
    if (seg0 !== 7'h00 || seg1 !== 7'h00) begin
      n_fail++;
      $display("FAIL reset_seg got=%h/%h exp=00/00", seg0, seg1);
    end
    if (en0 !== 2'b00) begin n_fail++; $display("FAIL reset_en0 got=%b exp=00", en0); end
    if (en1 !== 1'b0)  begin n_fail++; $display("FAIL reset_en1 got=%b exp=0", en1); end
    rst_n = 1'b1;
    exp_v0 = 0;
    exp_v1 = 0;
    sel = 0;
    check_scan(6 * CD);
    sel = 1;
    check_scan(2 * CD);
  endtask

  task automatic test_convert();
    convert(0, 31, 1'b0, 0);
    convert(0, 7, 1'b0, 0);
    convert(0, 0, 1'b0, 0);
    for (int k = 0; k < 6; k++) convert(0, int'($urandom_range(0, 31)), 1'b0, 0);
  endtask

  task automatic test_ignore_load();
    int a, b;
    convert(0, 31, 1'b1, 14);
    for (int k = 0; k < 3; k++) begin
      a = int'($urandom_range(0, 31));
      b = (a + 1 + int'($urandom_range(0, 29))) % 32;
      convert(0, a, 1'b1, b);
    end
  endtask

  task automatic test_ovf();
    convert(1, 12, 1'b0, 0);
    convert(1, 5, 1'b0, 0);
    convert(1, int'($urandom_range(10, 31)), 1'b0, 0);
    convert(1, int'($urandom_range(0, 9)), 1'b0, 0);
  endtask

  task automatic test_abort();
    sel = 0;
    drive(1'b1, DW'(27));
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      if (j == 1) drive(1'b0, DW'(27));
    end
    rst_n = 1'b0;
    #1;
    exp_v0 = 0;
    exp_v1 = 0;
    n_checks += 3;
    if ({busy0, done0, ovf0} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_flags got=%b exp=000", {busy0, done0, ovf0});
    end
    if (bcd0 !== 8'h00) begin n_fail++; $display("FAIL abort_bcd got=%h exp=00", bcd0); end
    if (seg0 !== 7'h00 || en0 !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_scan got=%h/%b exp=00/00", seg0, en0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < DW + 4; j++) begin
      @(negedge clk);
      n_checks++;
      if (done0 !== 1'b0 || busy0 !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet cyc=%0d got=%b%b exp=00", j, busy0, done0);
      end
    end
    convert(0, 9, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    localparam int N = 4;
    localparam int P = DW + 2;
    int vals[N];
    int ph, k;
    sel = 0;
    for (int i = 0; i < N; i++) vals[i] = int'($urandom_range(0, 31));
    drive(1'b1, DW'(vals[0]));
    for (int j = 1; j <= N * P; j++) begin
      @(negedge clk);
      ph = (j - 1) % P;
      if (ph == 0) begin
        k = (j - 1) / P;
        if (k + 1 < N) drive(1'b1, DW'(vals[k + 1]));
        else           drive(1'b0, '0);
      end
      n_checks += 2;
      if (s_done !== (ph == P - 1)) begin
        n_fail++;
        $display("FAIL b2b_done cyc=%0d got=%b exp=%b", j, s_done, (ph == P - 1));
      end
      if (s_busy !== (ph != P - 1)) begin
        n_fail++;
        $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", j, s_busy, (ph != P - 1));
      end
      if (ph == P - 1) begin
        n_checks++;
        if (s_bcd !== m_bcd(vals[j / P - 1], 2)) begin
          n_fail++;
          $display("FAIL b2b_bcd cyc=%0d got=%h exp=%h", j, s_bcd, m_bcd(vals[j / P - 1], 2));
        end
      end
    end
    exp_v0 = vals[N - 1];
    repeat (CD) @(negedge clk);
    check_scan(4 * CD + 1);
  endtask

  initial begin
    test_reset();
    test_convert();
    test_ignore_load();
    test_ovf();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Parametrised successor to the single-value combinational display decoder.
- Accepts a binary value through a load/busy handshake and converts it to BCD serially (shift-add-3, one bit per clock).
- Holds the result in a display register and drives a time-multiplexed multi-digit seven-segment display: one digit is enabled at a time, rotated by a clock prescaler.
- Sits between the datapath producing the value and the board display pins.

Parameters:
- DATA_W, 5: width of the binary input value.
- DIGITS, 2: number of display digits scanned.
- CLK_DIV, 1000: clock cycles per digit slot; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- value_in  in  DATA_W  binary value to display, sampled on accepted load.
- load  in  1  request to convert value_in; accepted only when busy=0.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when the display register updates.
- ovf  out  1  registered flag: last accepted value >= 10^DIGITS.
- bcd_out  out  4*DIGITS  committed display register; digit 0 = ones, in bits [3:0].
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high.
- digit_en  out  DIGITS  one-hot digit enable, active-high; bit i = digit i.

Behaviour:
- Single clock domain; one clock and one reset as decided: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values:
  - FSM = IDLE; busy=0, done=0, ovf=0, bcd_out=0.
  - Prescaler=0, digit index=0, seg=0, digit_en=0.
- Conversion FSM:
  - IDLE: load=1 captures value_in into a shift register, clears the BCD accumulator, sets bit counter=DATA_W, computes the ovf candidate (value_in >= 10^DIGITS, constant derived from DIGITS), moves to SHIFT. busy=1 from the next cycle.
  - SHIFT: each cycle, every BCD nibble >= 5 gets +3, then {bcd, shreg} shifts left by 1 and the counter decrements. After DATA_W shift cycles, moves to COMMIT.
  - COMMIT: bcd_out <= accumulator, ovf <= candidate, done=1 for this cycle only, busy=0, moves to IDLE.
  - Latency: load sampled at edge N; bcd_out, ovf and done valid after edge N+DATA_W+1.
  - load while busy=1 is ignored, not queued.
  - load held high in IDLE right after COMMIT starts a new conversion; back-to-back throughput is 1 value per DATA_W+2 cycles.
  - bcd_out holds the previous value during conversion; no partial results are visible.
- Accumulator width: 4*DIGITS bits; bits shifted beyond it are discarded. When ovf=1, bcd_out content is don't-care.
- Scan logic (independent of the FSM, always running):
  - Prescaler counts 0..CLK_DIV-1 and wraps; tick when count = CLK_DIV-1.
  - On tick, digit index advances modulo DIGITS (DIGITS-1 wraps to 0).
  - seg and digit_en are registered on tick from the index value after the advance.
  - First tick after reset selects digit 1 (digit 0 if DIGITS=1).
  - Between reset and the first tick, outputs stay dark.
- Segment decode (hex seg):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibble values 10-15 (unreachable) give 00.
- ovf=1: every digit shows 40 (dash) instead of the decoded digit.
- Display register update and scan tick on the same edge: the new bcd_out is used for the decoded digit.
- Reset asserted mid-conversion aborts immediately to reset values; no done pulse.

Optional Feature:
- Macro: DISPLAY_LEADING_BLANK_EN
- Defined:
  - Any digit i > 0 whose nibble and all higher nibbles are 0 shows seg=00.
  - Digit 0 is never blanked.
  - Blanking does not apply when ovf=1.
  - digit_en scanning is unchanged.
- Undefined: leading zeros are displayed as 3F.

Test Plan:
- Reset then idle, CLK_DIV=4, DIGITS=2:
  - seg=00 and digit_en=00 until the first tick.
  - Then digit_en alternates 10/01 every 4 cycles with seg=3F.
- load=1 with value_in=31 (DATA_W=5):
  - busy high for 6 cycles; done pulse 6 cycles after load.
  - bcd_out=0x31, ovf=0.
  - Scan shows seg=06 when digit_en=01 and 4F when digit_en=10.
- load pulsed again at cycle 2 of a busy conversion with a different value: ignored; bcd_out reflects only the first value.
- DIGITS=1, value_in=12: ovf=1; seg=40 on every tick; digit_en=1 constantly.
- rst_n pulsed low at cycle 3 of a conversion of 27:
  - All outputs return to reset values asynchronously; no done pulse.
  - Next load of 9 gives bcd_out=0x09.
- DISPLAY_LEADING_BLANK_EN defined, value 7, DIGITS=2: digit 1 seg=00, digit 0 seg=07. Undefined: digit 1 seg=3F.
